// File: rtl/hex_stream_pkg.sv
// rtl/hex_stream_pkg.sv - state encoding and ASCII constants for the hex streamer
// Optional prefix state compiled in by HEX_STREAMER_PREFIX_EN.
package hex_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef HEX_STREAMER_PREFIX_EN
        ST_PREFIX,
`endif
        ST_DIGITS,
        ST_CR,
        ST_LF
    } state_t;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_X    = 8'h78;
    localparam logic [7:0] ASCII_A    = 8'h41;

endpackage

// File: rtl/nibble_to_ascii.sv
// rtl/nibble_to_ascii.sv - combinational 4-bit value to uppercase ASCII hex digit
module nibble_to_ascii
    import hex_stream_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_ZERO + {4'b0000, nibble};
        end else begin
            ascii = ASCII_A + {4'b0000, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/hex_ascii_streamer.sv
// rtl/hex_ascii_streamer.sv - prints a binary word as hex ASCII + CR LF to a byte stream
// Define HEX_STREAMER_PREFIX_EN to prepend "0x" to every word.
module hex_ascii_streamer
    import hex_stream_pkg::*;
#(
    parameter int DATA_NIBBLES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*DATA_NIBBLES-1:0] word_in,
    input  logic                      word_valid,
    output logic                      word_ready,
    output logic [7:0]                tx_data,
    output logic                      tx_data_valid,
    input  logic                      tx_data_ready,
    output logic                      busy
);

    localparam int         W         = 4 * DATA_NIBBLES;
    localparam logic [3:0] LAST_DIGIT = 4'(DATA_NIBBLES - 1);

    state_t         state;
    logic [W-1:0]   word_q;
    logic [3:0]     cnt;
    logic [3:0]     sel_cnt;
    logic [W-1:0]   sel_word;
    logic [W-1:0]   shifted;
    logic [5:0]     pos;
    logic [3:0]     nibble;
    logic [7:0]     digit_ascii;
    logic           hs;
`ifdef HEX_STREAMER_PREFIX_EN
    logic           prefix_second;
`endif

    assign hs         = tx_data_valid && tx_data_ready;
    assign word_ready = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);

    // Select the digit that will be presented next: the first digit comes
    // straight from word_in at acceptance, later ones from the captured word.
    always_comb begin
        sel_word = (state == ST_IDLE) ? word_in : word_q;
        sel_cnt  = (state == ST_DIGITS) ? (cnt + 4'd1) : 4'd0;
        pos      = 6'(DATA_NIBBLES - 1) - {2'b00, sel_cnt};
        shifted  = sel_word >> {pos, 2'b00};
        nibble   = shifted[3:0];
    end

    nibble_to_ascii u_nibble_to_ascii (
        .nibble (nibble),
        .ascii  (digit_ascii)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            tx_data       <= 8'h00;
            tx_data_valid <= 1'b0;
            cnt           <= 4'd0;
            word_q        <= '0;
`ifdef HEX_STREAMER_PREFIX_EN
            prefix_second <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (word_valid) begin
                        word_q        <= word_in;
                        cnt           <= 4'd0;
                        tx_data_valid <= 1'b1;
`ifdef HEX_STREAMER_PREFIX_EN
                        state         <= ST_PREFIX;
                        prefix_second <= 1'b0;
                        tx_data       <= ASCII_ZERO;
`else
                        state         <= ST_DIGITS;
                        tx_data       <= digit_ascii;
`endif
                    end
                end
`ifdef HEX_STREAMER_PREFIX_EN
                ST_PREFIX: begin
                    if (hs) begin
                        if (!prefix_second) begin
                            prefix_second <= 1'b1;
                            tx_data       <= ASCII_X;
                        end else begin
                            state   <= ST_DIGITS;
                            tx_data <= digit_ascii;
                        end
                    end
                end
`endif
                ST_DIGITS: begin
                    if (hs) begin
                        if (cnt == LAST_DIGIT) begin
                            state   <= ST_CR;
                            tx_data <= ASCII_CR;
                        end else begin
                            cnt     <= cnt + 4'd1;
                            tx_data <= digit_ascii;
                        end
                    end
                end
                ST_CR: begin
                    if (hs) begin
                        state   <= ST_LF;
                        tx_data <= ASCII_LF;
                    end
                end
                ST_LF: begin
                    if (hs) begin
                        state         <= ST_IDLE;
                        tx_data_valid <= 1'b0;
                        tx_data       <= 8'h00;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    tx_data_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_ascii_streamer.sv
// tb/tb_hex_ascii_streamer.sv - directed vector bench for hex_ascii_streamer (HEX_STREAMER_PREFIX_EN aware)
module tb_hex_ascii_streamer;

`ifdef HEX_STREAMER_PREFIX_EN
    localparam int P = 2;
`else
    localparam int P = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic        busy;

    hex_ascii_streamer #(.DATA_NIBBLES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .word_in       (word_in),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] byte_q[$];
    logic [7:0] exp_q[$];
    int         hs_q[$];
    int         acc_q[$];
    int         acc_rc_q[$];
    int         rc = 0;
    int         checks = 0;
    int         errors = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (word_ready) rc = rc + 1;
            if (word_valid && word_ready) begin
                acc_q.push_back(cyc);
                acc_rc_q.push_back(rc);
            end
            if (tx_data_valid && tx_data_ready) begin
                byte_q.push_back(tx_data);
                hs_q.push_back(cyc);
            end
        end
    end

    typedef struct {
        logic [31:0] word;
        logic [63:0] digits;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        byte_q.delete();
        hs_q.delete();
        acc_q.delete();
        acc_rc_q.delete();
    endtask

    task automatic add_exp(input logic [63:0] dig);
        if (P == 2) begin
            exp_q.push_back(8'h30);
            exp_q.push_back(8'h78);
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(dig[63-8*i -: 8]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        while (!word_ready && n < 200) begin
            tick();
            n++;
        end
        check("send_ready", word_ready, 1);
        word_in    = w;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
    endtask

    task automatic wait_done(output int done_cyc);
        int n = 0;
        done_cyc = -1;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (!busy) begin
                done_cyc = cyc;
                break;
            end
        end
        check("done_timeout", busy, 0);
        tick();
    endtask

    task automatic compare_msg(input string name);
        check($sformatf("%s_len", name), byte_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < byte_q.size())
                check($sformatf("%s_byte%0d", name, i), byte_q[i], exp_q[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  d;
        bit  consec;

        vecs[0] = '{32'h1234ABCD, 64'h31323334_41424344};
        vecs[1] = '{32'h0000FFFF, 64'h30303030_46464646};
        vecs[2] = '{32'hDEADBEEF, 64'h44454144_42454546};
        vecs[3] = '{32'h89ABCDEF, 64'h38394142_43444546};
        vecs[4] = '{32'h00000000, 64'h30303030_30303030};
        vecs[5] = '{32'hFFFFFFFF, 64'h46464646_46464646};

        rst           = 1'b1;
        word_in       = 32'h0;
        word_valid    = 1'b0;
        tx_data_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("rst_word_ready", word_ready, 1);
        check("rst_valid", tx_data_valid, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // Full-rate streams with latency and busy-fall timing
        for (int v = 0; v < 6; v++) begin
            clear_logs();
            exp_q.delete();
            add_exp(vecs[v].digits);
            send_word(vecs[v].word);
            wait_done(d);
            compare_msg($sformatf("vec%0d", v));
            if (hs_q.size() == exp_q.size() && acc_q.size() == 1) begin
                check($sformatf("vec%0d_first_latency", v), hs_q[0], acc_q[0] + 1);
                consec = 1'b1;
                for (int i = 0; i < hs_q.size(); i++)
                    if (hs_q[i] != hs_q[0] + i) consec = 1'b0;
                check($sformatf("vec%0d_consecutive", v), consec, 1);
                check($sformatf("vec%0d_busy_fall", v), d, hs_q[hs_q.size()-1] + 1);
            end else begin
                check($sformatf("vec%0d_timing_logs", v), hs_q.size(), exp_q.size());
            end
        end

        // Back-pressure during the third digit
        clear_logs();
        exp_q.delete();
        add_exp(64'h31323334_41424344);
        tx_data_ready = 1'b1;
        send_word(32'h1234ABCD);
        repeat (P + 2) tick();
        tx_data_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_data", i), tx_data, 8'h33);
            check($sformatf("stall%0d_valid", i), tx_data_valid, 1);
            tick();
        end
        tx_data_ready = 1'b1;
        wait_done(d);
        compare_msg("stall");

        // word_valid while streaming is ignored
        clear_logs();
        exp_q.delete();
        add_exp(64'h30303030_30303031);
        send_word(32'h00000001);
        repeat (2) tick();
        check("ignore_ready_low", word_ready, 0);
        word_in    = 32'hDEADBEEF;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        wait_done(d);
        compare_msg("ignore");
        check("ignore_accepts", acc_q.size(), 1);

        // Reset after the fourth byte
        clear_logs();
        exp_q.delete();
        add_exp(64'h43414645_46303044);
        send_word(32'hCAFEF00D);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mrst_valid", tx_data_valid, 0);
        check("mrst_word_ready", word_ready, 1);
        check("mrst_busy", busy, 0);
        check("mrst_bytes", byte_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < byte_q.size()) check($sformatf("mrst_byte%0d", i), byte_q[i], exp_q[i]);
        @(posedge clk);
        #1;
        clear_logs();
        exp_q.delete();
        add_exp(64'h38394142_43444546);
        send_word(32'h89ABCDEF);
        wait_done(d);
        compare_msg("after_rst");

        // Back-to-back words with word_valid held
        clear_logs();
        exp_q.delete();
        add_exp(64'h46464646_46464646);
        add_exp(64'h30303030_30303030);
        word_in    = 32'hFFFFFFFF;
        word_valid = 1'b1;
        tick();
        word_in    = 32'h00000000;
        for (int n = 0; n < 100 && acc_q.size() < 2; n++) @(negedge clk);
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        wait_done(d);
        compare_msg("b2b");
        check("b2b_accepts", acc_q.size(), 2);
        if (acc_q.size() == 2 && hs_q.size() > P + 9) begin
            check("b2b_gap", acc_q[1], hs_q[P+9] + 1);
            check("b2b_ready_cycles", acc_rc_q[1] - acc_rc_q[0], 1);
        end else begin
            check("b2b_logs", hs_q.size(), 2 * (P + 10));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
